// File: rtl/tcdm_sram_responder_if.sv
// TCDM request/response bundle between a crossbar master port and a slave bank.
// The master drives the request fields and holds them stable until gnt; the
// slave returns gnt combinationally and the response one cycle later.
interface tcdm_sram_responder_if;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic        r_valid;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_rdata, r_opc, r_valid
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_rdata, r_opc, r_valid
  );
endinterface

// File: rtl/tcdm_sram_responder.sv
// TCDM slave responder: a word-addressed memory behind one crossbar port,
// with a programmable number of wait states before the grant and a response
// registered one cycle after the grant.
// Optional feature: define TCDM_RESP_ERR_EN to range-check the address and
// answer out-of-range requests with r_opc=1 and 32'hBADA_CCE5 without touching
// the memory. Without it the address simply wraps onto the index bits.
module tcdm_sram_responder #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned INTERLEAVE  = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  tcdm_sram_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned IL_W     = $clog2(INTERLEAVE);
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);
  localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              grant;
  logic              inRange;
  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       mem [NUM_WORDS];
  logic              rValid_q;
  logic [31:0]       rData_q;
  logic              rOpc_q;
  logic              unusedAddr;

  // The port-select bits of the interleaved crossbar sit just above the byte
  // offset, so the word index starts after them.
  assign wordIdx    = bus.add[2+IL_W +: IDX_W];
  assign unusedAddr = ^bus.add;

`ifdef TCDM_RESP_ERR_EN
  localparam logic [32:0] SPAN = 33'(NUM_WORDS) * 33'd4 * 33'(INTERLEAVE);
  logic [32:0] offset;
  // A borrow out of the 33-bit subtraction means the address is below the base.
  assign offset  = {1'b0, bus.add} - {1'b0, BASE_ADDR};
  assign inRange = !offset[32] && (offset < SPAN);
`else
  assign inRange = 1'b1;
`endif

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next state: count wait states while req is held, abort if req drops.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req && (WAIT_LIM != 4'd0)) begin
          state_d   = WAIT;
          waitCnt_d = 4'd1;
        end
      end
      WAIT: begin
        if (!bus.req || (waitCnt_q == WAIT_LIM)) begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  // Grant decode; held low while reset is asserted so nothing is accepted.
  always_comb begin
    grant = 1'b0;
    case (state_q)
      IDLE:    grant = bus.req && (WAIT_LIM == 4'd0);
      WAIT:    grant = bus.req && (waitCnt_q == WAIT_LIM);
      default: grant = 1'b0;
    endcase
    grant = grant && rst_ni;
  end

  // Byte-enabled memory write at the grant edge; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (grant && !bus.wen && inRange) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be[k]) begin
          mem[wordIdx][8*k +: 8] <= bus.wdata[8*k +: 8];
        end
      end
    end
  end

  // Response register: one-cycle valid pulse per grant, data/opc held between.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rValid_q <= 1'b0;
      rData_q  <= '0;
      rOpc_q   <= 1'b0;
    end else if (grant) begin
      rValid_q <= 1'b1;
      if (!inRange) begin
        rData_q <= ERR_DATA;
        rOpc_q  <= 1'b1;
      end else if (bus.wen) begin
        rData_q <= mem[wordIdx];
        rOpc_q  <= 1'b0;
      end else begin
        rData_q <= '0;
        rOpc_q  <= 1'b0;
      end
    end else begin
      rValid_q <= 1'b0;
    end
  end

  assign bus.gnt     = grant;
  assign bus.r_valid = rValid_q;
  assign bus.r_rdata = rData_q;
  assign bus.r_opc   = rOpc_q;

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// Bench for tcdm_sram_responder: one zero-wait interleaved instance driven
// with directed and random traffic against a reference memory, and one
// three-wait-state instance for latency, abort and reset-in-grant behaviour.
module tb_tcdm_sram_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam int NWA = 64;
  localparam int ILA = 4;
  localparam int NWB = 32;
  localparam logic [31:0] ERR_WORD = 32'hBADA_CCE5;
`ifdef TCDM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int compareCnt = 0;
  int failCnt = 0;

  // Reference memories: word contents and whether each word is known.
  logic [31:0] memA [NWA];
  bit          knownA [NWA];
  logic [31:0] memB [NWB];
  bit          knownB [NWB];

  // Response expected from instance A at the next cycle.
  bit          pendValid = 1'b0;
  bit          pendCheck = 1'b0;
  logic [31:0] pendData = '0;
  logic        pendOpc = 1'b0;

  always #5 clk = ~clk;

  tcdm_sram_responder_if busA ();
  tcdm_sram_responder_if busB ();

  tcdm_sram_responder #(
    .NUM_WORDS(NWA), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INTERLEAVE(ILA)
  ) dutA (
    .clk_i(clk), .rst_ni(rst_ni), .bus(busA)
  );

  tcdm_sram_responder #(
    .NUM_WORDS(NWB), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .INTERLEAVE(1)
  ) dutB (
    .clk_i(clk), .rst_ni(rst_ni), .bus(busB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit inWindow(input logic [31:0] a, input int nw, input int il);
    longint lo;
    longint hi;
    lo = longint'(BASE);
    hi = lo + longint'(nw) * 4 * longint'(il);
    return !ERR_EN || ((longint'(a) >= lo) && (longint'(a) < hi));
  endfunction

  function automatic int idxOf(input logic [31:0] a, input int nw, input int il);
    return int'((longint'(a) / (4 * longint'(il))) % longint'(nw));
  endfunction

  // One cycle on instance A: check last cycle's response, drive, check gnt,
  // then advance the reference model.
  task automatic applyStimulus(input bit rq, input logic [31:0] a, input bit w,
                               input logic [3:0] b, input logic [31:0] d);
    int i;
    @(negedge clk);
    checkOutput("A r_valid", 32'(busA.r_valid), 32'(pendValid));
    if (pendValid && pendCheck) begin
      checkOutput("A r_rdata", busA.r_rdata, pendData);
      checkOutput("A r_opc", 32'(busA.r_opc), 32'(pendOpc));
    end
    busA.req = rq;
    busA.add = a;
    busA.wen = w;
    busA.be = b;
    busA.wdata = d;
    #1;
    checkOutput("A gnt", 32'(busA.gnt), 32'(rq));
    pendValid = rq;
    pendCheck = 1'b1;
    if (rq) begin
      i = idxOf(a, NWA, ILA);
      if (!inWindow(a, NWA, ILA)) begin
        pendData = ERR_WORD;
        pendOpc = 1'b1;
      end else if (w) begin
        pendData = memA[i];
        pendCheck = knownA[i];
        pendOpc = 1'b0;
      end else begin
        pendData = '0;
        pendOpc = 1'b0;
        for (int k = 0; k < 4; k++) if (b[k]) memA[i][8*k +: 8] = d[8*k +: 8];
        knownA[i] = knownA[i] || (b == 4'hF);
      end
    end
  endtask

  // One complete transaction on instance B with its latency and response.
  task automatic applyStimulusWait(input logic [31:0] a, input bit w,
                                   input logic [3:0] b, input logic [31:0] d);
    int lat;
    bit got;
    int i;
    logic [31:0] eData;
    logic eOpc;
    bit eCheck;
    @(negedge clk);
    busB.req = 1'b1;
    busB.add = a;
    busB.wen = w;
    busB.be = b;
    busB.wdata = d;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      if (busB.gnt === 1'b1) got = 1'b1;
      else begin
        checkOutput("B r_valid while waiting", 32'(busB.r_valid), 32'd0);
        @(negedge clk);
        lat++;
      end
    end
    checkOutput("B grant latency", lat, 32'd3);
    i = idxOf(a, NWB, 1);
    eCheck = 1'b1;
    if (!inWindow(a, NWB, 1)) begin
      eData = ERR_WORD;
      eOpc = 1'b1;
    end else if (w) begin
      eData = memB[i];
      eCheck = knownB[i];
      eOpc = 1'b0;
    end else begin
      eData = '0;
      eOpc = 1'b0;
      for (int k = 0; k < 4; k++) if (b[k]) memB[i][8*k +: 8] = d[8*k +: 8];
      knownB[i] = knownB[i] || (b == 4'hF);
    end
    @(negedge clk);
    busB.req = 1'b0;
    checkOutput("B r_valid", 32'(busB.r_valid), 32'd1);
    if (eCheck) begin
      checkOutput("B r_rdata", busB.r_rdata, eData);
      checkOutput("B r_opc", 32'(busB.r_opc), 32'(eOpc));
    end
    @(negedge clk);
    checkOutput("B r_valid pulse end", 32'(busB.r_valid), 32'd0);
  endtask

  initial begin
    bit got;
    logic [31:0] a;
    $display("[TB] start, error response %s", ERR_EN ? "enabled" : "disabled");
    for (int i = 0; i < NWA; i++) knownA[i] = 1'b0;
    for (int i = 0; i < NWB; i++) knownB[i] = 1'b0;
    busA.req = 1'b1; busA.add = BASE; busA.wen = 1'b1; busA.be = '0; busA.wdata = '0;
    busB.req = 1'b0; busB.add = BASE; busB.wen = 1'b1; busB.be = '0; busB.wdata = '0;

    // Reset state, with a request pending on A that must not be granted.
    #12;
    checkOutput("reset A gnt", 32'(busA.gnt), 32'd0);
    checkOutput("reset A r_valid", 32'(busA.r_valid), 32'd0);
    checkOutput("reset A r_rdata", busA.r_rdata, 32'd0);
    checkOutput("reset A r_opc", 32'(busA.r_opc), 32'd0);
    checkOutput("reset B gnt", 32'(busB.gnt), 32'd0);
    checkOutput("reset B r_valid", 32'(busB.r_valid), 32'd0);
    busA.req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Fill A with streaming full-word writes.
    for (int i = 0; i < NWA; i++) applyStimulus(1'b1, BASE + 32'(i * 16), 1'b0, 4'hF, $urandom);

    // Write then read the same word in consecutive cycles.
    applyStimulus(1'b1, BASE + 32'h10, 1'b0, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);

    // Partial write over a known pattern.
    applyStimulus(1'b1, BASE + 32'h20, 1'b0, 4'hF, 32'hAAAA_AAAA);
    applyStimulus(1'b1, BASE + 32'h20, 1'b0, 4'b0101, 32'h1122_3344);
    applyStimulus(1'b1, BASE + 32'h20, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b0, BASE, 1'b1, 4'h0, 32'h0);
    checkOutput("A partial write readback", pendData, 32'hAA22_AA44);

    // Eight streaming reads in address order.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, BASE + 32'(i * 16), 1'b1, 4'h0, 32'h0);

    // Below-window read, beyond-window write, then readback of word 0.
    applyStimulus(1'b1, BASE - 32'd4, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b1, BASE + 32'h400, 1'b0, 4'hF, 32'h5A5A_0FF0);
    applyStimulus(1'b1, BASE, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b0, BASE, 1'b1, 4'h0, 32'h0);

    // Random traffic, including byte offsets, port-select bits and strays.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64) * 4)
                                        : BASE + 32'h400 + 32'($urandom_range(0, 255) * 4);
      end else begin
        a = BASE + 32'($urandom_range(0, NWA * ILA - 1) * 4) + 32'($urandom_range(0, 3));
      end
      applyStimulus($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom);
    end
    applyStimulus(1'b0, BASE, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b0, BASE, 1'b1, 4'h0, 32'h0);

    // Instance B: wait-state write and read.
    applyStimulusWait(BASE + 32'h8, 1'b0, 4'hF, 32'h1234_5678);
    applyStimulusWait(BASE + 32'h8, 1'b1, 4'h0, 32'h0);
    applyStimulusWait(BASE + 32'hC, 1'b0, 4'b1010, 32'hCAFE_F00D);

    // Abort after two cycles: no grant, no response.
    @(negedge clk);
    busB.req = 1'b1; busB.wen = 1'b1; busB.add = BASE + 32'h8;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("B abort gnt", 32'(busB.gnt), 32'd0);
      @(negedge clk);
      if (c == 1) busB.req = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput("B abort r_valid", 32'(busB.r_valid), 32'd0);
      @(negedge clk);
    end
    applyStimulusWait(BASE + 32'h8, 1'b1, 4'h0, 32'h0);

    // Reset asserted in the grant cycle of a read.
    @(negedge clk);
    busB.req = 1'b1; busB.wen = 1'b1; busB.add = BASE + 32'h8;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      if (busB.gnt === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checkOutput("B gnt before reset", 32'(got), 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("B gnt in reset", 32'(busB.gnt), 32'd0);
    checkOutput("B r_valid in reset", 32'(busB.r_valid), 32'd0);
    checkOutput("B r_rdata in reset", busB.r_rdata, 32'd0);
    checkOutput("B r_opc in reset", 32'(busB.r_opc), 32'd0);
    @(negedge clk);
    busB.req = 1'b0;
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("B r_valid after reset", 32'(busB.r_valid), 32'd0);
    end
    applyStimulusWait(BASE + 32'h8, 1'b1, 4'h0, 32'h0);

    // Instance A after the reset: memory kept, response path working.
    pendValid = 1'b0;
    applyStimulus(1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b0, BASE, 1'b1, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/tcdm_sram_responder.md
# tcdm_sram_responder

TCDM slave-side responder terminating one output port of the interleaved L2 crossbar. Accepts single-word TCDM requests, services them from an internal word-addressed memory with a programmable number of wait states, and returns the one-cycle-latency response (data, opc, valid) that the crossbar expects for reads and writes alike. It serves as the behavioural/FPGA L2 bank model and as a bring-up slave for crossbar verification.

## Interface
- NUM_WORDS, 1024: memory depth in 32-bit words; power of two, ≥2.
- BASE_ADDR, 32'h1C00_0000: byte address of word 0; aligned to NUM_WORDS*4.
- WAIT_CYCLES, 0: wait states inserted before gnt; 0..15.
- INTERLEAVE, 1: number of banks sharing the address space; power of two. Word index skips the log2(INTERLEAVE) port-select bits above bit 1.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- add_i  in  32  byte address.
- wen_i  in  1  1 = read, 0 = write.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- gnt_o  out  1  request accepted this cycle.
- r_rdata_o  out  32  read data.
- r_opc_o  out  1  response error flag.
- r_valid_o  out  1  response valid, one cycle after gnt.

## Operation
- The master holds req_i, add_i, wen_i, be_i, wdata_i stable from request assertion until the gnt cycle.
- FSM states: IDLE, WAIT.
  - IDLE, req_i=1, WAIT_CYCLES=0: gnt_o=1 combinationally; stay IDLE.
  - IDLE, req_i=1, WAIT_CYCLES>0: gnt_o=0, load wait counter with 1, go WAIT.
  - WAIT: if req_i=0, abort (counter cleared, back to IDLE, no response). If counter==WAIT_CYCLES: gnt_o=1, go IDLE. Otherwise, increment the counter.
- Word index = add_i[2+log2(INTERLEAVE) +: log2(NUM_WORDS)]. add_i[1:0] is ignored.
- Write at gnt: for each be_i[k]=1, mem[idx][8k+7:8k] <= wdata_i[8k+7:8k]. be_i=0 writes nothing but still responds.
- Read at gnt: r_rdata_o registered from mem[idx] and valid in the next cycle.
- Write responses: r_valid_o=1, r_rdata_o=0, r_opc_o=0.
- Read-after-write to the same word in consecutive grants returns the new data (memory write completes at the gnt edge).
- Memory contents are not reset.

## Timing
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, FSM=IDLE, counter=0.
- gnt-to-r_valid latency is exactly 1 cycle. r_valid_o is a single-cycle pulse per grant. There is no response backpressure.
- Throughput:
  - WAIT_CYCLES=0: one grant per cycle.
  - WAIT_CYCLES=N: one grant per N+1 cycles per request.
- Back-to-back grants produce back-to-back r_valid_o pulses.
- r_rdata_o and r_opc_o hold their values until the next response. They are don't-care when r_valid_o=0, but are driven 0 after reset.
- Asynchronous reset mid-wait or with a response pending: the response is dropped, all outputs go to their reset values immediately, and the FSM goes to IDLE.

## Configuration
- TCDM_RESP_ERR_EN defined:
  - A request whose add_i lies outside [BASE_ADDR, BASE_ADDR+NUM_WORDS*4*INTERLEAVE) is still granted with normal wait states.
  - Memory is not accessed.
  - Response has r_opc_o=1 and r_rdata_o=32'hBADA_CCE5, for both reads and writes.
- TCDM_RESP_ERR_EN undefined: no range check. The address is wrapped modulo the index width, and r_opc_o is constant 0.

## Test plan
- WAIT_CYCLES=0: write 0xDEADBEEF, be=4'hF, to BASE_ADDR+0x10, then read the same address next cycle -> gnt in the same cycle both times; r_valid pulses at cycles +1 and +2; read r_rdata=0xDEADBEEF, r_opc=0.
- Partial write be=4'b0101, wdata=0x11223344 over existing 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- WAIT_CYCLES=3: hold a read request -> gnt rises exactly 3 cycles after req; r_valid 1 cycle later. Drop req after 2 cycles -> no gnt, no r_valid, and the next request again waits 3 cycles.
- Streaming 8 reads with WAIT_CYCLES=0 -> 8 consecutive gnt cycles and 8 consecutive r_valid cycles with data in address order.
- TCDM_RESP_ERR_EN defined: read at BASE_ADDR-4 -> r_opc=1, r_rdata=0xBADACCE5. Write out of range -> r_opc=1, and memory is unchanged on readback. Macro undefined: same read -> r_opc=0, data from the wrapped index.
- Assert rst_ni low in the gnt cycle of a read -> r_valid_o stays 0 after release; FSM IDLE; a new request behaves as from reset.
